// File: rtl/aesl_deadlock_aggregator_if.sv
// Bundle between the deadlock monitors' testbench glue and the aggregator.
// Trace signals exist only when AESL_DEADLOCK_AGG_TRACE_EN is defined.
interface aesl_deadlock_aggregator_if #(
    parameter int NUM_MON = 4,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = 2
);
    logic               enable;
    logic               ap_done;
    logic [NUM_MON-1:0] mon_block;
    logic               suspect;
    logic               deadlock;
    logic [NUM_MON-1:0] deadlock_mask;
    logic [IDX_W-1:0]   first_idx;
    logic [CNT_W-1:0]   block_run_cnt;
`ifdef AESL_DEADLOCK_AGG_TRACE_EN
    logic [CNT_W-1:0]   cycle_stamp;
    logic [CNT_W-1:0]   first_block_cycle;
`endif

    modport master (
        output enable, ap_done, mon_block,
`ifdef AESL_DEADLOCK_AGG_TRACE_EN
        input  cycle_stamp, first_block_cycle,
`endif
        input  suspect, deadlock, deadlock_mask, first_idx, block_run_cnt
    );

    modport slave (
        input  enable, ap_done, mon_block,
`ifdef AESL_DEADLOCK_AGG_TRACE_EN
        output cycle_stamp, first_block_cycle,
`endif
        output suspect, deadlock, deadlock_mask, first_idx, block_run_cnt
    );
endinterface

// File: rtl/aesl_deadlock_aggregator.sv
// Aggregates monitor block bits; declares a sticky deadlock after THRESHOLD
// consecutive blocked cycles. Optional trace: AESL_DEADLOCK_AGG_TRACE_EN.
module aesl_deadlock_aggregator #(
    parameter int NUM_MON   = 4,
    parameter int THRESHOLD = 1000,
    parameter int CNT_W     = 32,
    parameter int IDX_W     = 2
) (
    input  logic clock,
    input  logic reset_n,
    aesl_deadlock_aggregator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WATCH, SUSPECT, REPORTED} state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [NUM_MON-1:0] mask_q, mask_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic               dl_q, dl_nxt;
    logic               any_blk, stop, hit;
    logic [CNT_W-1:0]   cnt_inc;

    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_MON-1:0] v);
        lowest = '0;
        for (int i = NUM_MON - 1; i >= 0; i--)
            if (v[i]) lowest = IDX_W'(i);
    endfunction

    assign any_blk = |bus.mon_block;
    assign stop    = bus.ap_done | ~bus.enable;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign hit     = (cnt_inc == CNT_W'(THRESHOLD));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            dl_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            mask_q  <= mask_nxt;
            idx_q   <= idx_nxt;
            dl_q    <= dl_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:     if (!stop) state_nxt = WATCH;
            WATCH:    if (stop) state_nxt = IDLE;
                      else if (any_blk) state_nxt = SUSPECT;
            SUSPECT:  if (stop) state_nxt = IDLE;
                      else if (!any_blk) state_nxt = WATCH;
                      else if (hit) state_nxt = REPORTED;
            default:  state_nxt = REPORTED;
        endcase
    end

    // Run bookkeeping; anything that leaves the run clears it, REPORTED freezes it.
    always_comb begin
        cnt_nxt  = cnt_q;
        mask_nxt = mask_q;
        idx_nxt  = idx_q;
        dl_nxt   = dl_q;
        case (state_q)
            IDLE: begin
                cnt_nxt  = '0;
                mask_nxt = '0;
                idx_nxt  = '0;
            end
            WATCH: begin
                cnt_nxt  = '0;
                mask_nxt = '0;
                idx_nxt  = '0;
                if (!stop && any_blk) begin
                    cnt_nxt  = CNT_W'(1);
                    mask_nxt = bus.mon_block;
                    idx_nxt  = lowest(bus.mon_block);
                end
            end
            SUSPECT: begin
                if (stop || !any_blk) begin
                    cnt_nxt  = '0;
                    mask_nxt = '0;
                    idx_nxt  = '0;
                end else begin
                    cnt_nxt  = cnt_inc;
                    mask_nxt = mask_q | bus.mon_block;
                    if (hit) dl_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.suspect       = (state_q == SUSPECT);
    assign bus.deadlock      = dl_q;
    assign bus.deadlock_mask = mask_q;
    assign bus.first_idx     = idx_q;
    assign bus.block_run_cnt = cnt_q;

`ifdef AESL_DEADLOCK_AGG_TRACE_EN
    logic [CNT_W-1:0] cyc_q, fbc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
            fbc_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (state_q == WATCH && state_nxt == SUSPECT)
                fbc_q <= cyc_q;
            else if ((state_q == SUSPECT && state_nxt != SUSPECT && state_nxt != REPORTED)
                     || state_q == IDLE || state_q == WATCH)
                fbc_q <= '0;
        end
    end

    always @(posedge clock) begin
        if (reset_n && state_q == SUSPECT && state_nxt == REPORTED)
            $display("aesl_deadlock_aggregator: deadlock first_idx=%0d mask=%b first_block_cycle=%0d",
                     idx_q, mask_nxt, fbc_q);
    end

    assign bus.cycle_stamp       = cyc_q;
    assign bus.first_block_cycle = fbc_q;
`endif
endmodule

// File: tb/tb_aesl_deadlock_aggregator.sv
// Directed, table-driven bench for aesl_deadlock_aggregator (THRESHOLD=8, NUM_MON=4).
module tb_aesl_deadlock_aggregator;
    localparam int NUM_MON   = 4;
    localparam int THRESHOLD = 8;
    localparam int CNT_W     = 32;
    localparam int IDX_W     = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    aesl_deadlock_aggregator_if #(.NUM_MON(NUM_MON), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

    aesl_deadlock_aggregator #(
        .NUM_MON(NUM_MON), .THRESHOLD(THRESHOLD), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        bit               rst;
        bit               en;
        bit               ad;
        logic [3:0]       mon;
        bit               s;
        bit               d;
        logic [3:0]       mask;
        logic [IDX_W-1:0] idx;
        int               cnt;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int failures = 0;

    task automatic add(input bit rst, input bit en, input bit ad, input logic [3:0] mon,
                       input bit s, input bit d, input logic [3:0] mask,
                       input logic [IDX_W-1:0] idx, input int cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.ad = ad; v.mon = mon;
        v.s = s; v.d = d; v.mask = mask; v.idx = idx; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input bit s, input bit d, input logic [3:0] mask,
                         input logic [IDX_W-1:0] idx, input int cnt);
        checks++;
        if (bus.suspect !== s || bus.deadlock !== d || bus.deadlock_mask !== mask ||
            bus.first_idx !== idx || bus.block_run_cnt !== CNT_W'(cnt)) begin
            failures++;
            $display("FAIL %s: got s=%b d=%b mask=%b idx=%0d cnt=%0d, want s=%b d=%b mask=%b idx=%0d cnt=%0d",
                     name, bus.suspect, bus.deadlock, bus.deadlock_mask, bus.first_idx,
                     bus.block_run_cnt, s, d, mask, idx, cnt);
        end
    endtask

    // Async reset inside the low clock phase; outputs must clear before any edge.
    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        check("async_reset", 0, 0, 4'b0000, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.ap_done = 1'b0;
        bus.mon_block = '0;

        // Phase 2: steady 0100 -> deadlock on 8th edge
        for (int k = 1; k <= 8; k++)
            add(0, 1, 0, 4'b0100, k < 8, k == 8, 4'b0100, 2, k);
        // Phase 3: run broken by a single clear cycle, never reaches threshold
        add(1, 1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        for (int k = 1; k <= 5; k++) add(0, 1, 0, 4'b1000, 1, 0, 4'b1000, 3, k);
        add(0, 1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        for (int k = 1; k <= 7; k++) add(0, 1, 0, 4'b1000, 1, 0, 4'b1000, 3, k);
        add(0, 1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        // Phase 4: alternating blockers keep the run alive
        for (int k = 1; k <= 8; k++)
            add(0, 1, 0, (k % 2) ? 4'b0010 : 4'b1000, k < 8, k == 8,
                (k == 1) ? 4'b0010 : 4'b1010, 1, k);
        // Phase 5: ap_done on the 6th blocked cycle aborts to IDLE
        add(1, 1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        for (int k = 1; k <= 5; k++) add(0, 1, 0, 4'b0100, 1, 0, 4'b0100, 2, k);
        add(0, 1, 1, 4'b0100, 0, 0, 4'b0000, 0, 0);
        add(0, 1, 0, 4'b0100, 0, 0, 4'b0000, 0, 0);
        add(0, 1, 0, 4'b0100, 1, 0, 4'b0100, 2, 1);
        // enable drop in SUSPECT also aborts
        add(0, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 0);
        // Phase 6: deadlock then frozen against ap_done/enable/mon_block
        add(0, 1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 0, 4'b0001, k < 8, k == 8, 4'b0001, 0, k);
        add(0, 1, 1, 4'b0000, 0, 1, 4'b0001, 0, 8);
        add(0, 0, 0, 4'b1110, 0, 1, 4'b0001, 0, 8);

        // Phase 1: reset, then 20 idle cycles with enable high
        #3;
        check("reset_state", 0, 0, 4'b0000, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            check("idle_watch", 0, 0, 4'b0000, 0, 0);
        end

        foreach (vq[i]) begin
            @(negedge clock);
            if (vq[i].rst) pulse_reset();
            bus.enable    = vq[i].en;
            bus.ap_done   = vq[i].ad;
            bus.mon_block = vq[i].mon;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), vq[i].s, vq[i].d, vq[i].mask, vq[i].idx, vq[i].cnt);
        end

        // Mid-cycle reset from REPORTED clears outputs without an edge
        #2;
        reset_n = 1'b0;
        #1;
        check("midcycle_reset", 0, 0, 4'b0000, 0, 0);
        #10;
        check("held_reset", 0, 0, 4'b0000, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aesl_deadlock_aggregator.md
Name: aesl_deadlock_aggregator

Overview:
- Simulation-side consumer of the per-instance deadlock monitors in the deQAM testbench.
- Collects the `block` outputs of NUM_MON monitors and tracks consecutive blocked cycles.
- Declares deadlock once blocking persists for THRESHOLD cycles, then latches which monitors were involved.
- Drives the testbench's deadlock report and abort logic.

Parameters:
- NUM_MON, 4, number of monitor `block` inputs aggregated.
- THRESHOLD, 1000, consecutive blocked cycles required to declare deadlock (must be >= 2).
- CNT_W, 32, width of the blocked-run counter (2^CNT_W > THRESHOLD).
- IDX_W, 2, width of first-blocker index ($clog2(NUM_MON), min 1).

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  design under test running (ap_start seen, not finished).
- ap_done  in  1  DUT completion pulse.
- mon_block  in  NUM_MON  one bit per monitor `block` output.
- suspect  out  1  blocking run in progress (state SUSPECT).
- deadlock  out  1  sticky deadlock flag.
- deadlock_mask  out  NUM_MON  OR of all mon_block vectors sampled during the current or fatal run.
- first_idx  out  IDX_W  lowest set bit of mon_block on the first cycle of the run.
- block_run_cnt  out  CNT_W  consecutive blocked cycles in the current run.

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous release):
  - state=IDLE.
  - All outputs 0.
- Definitions:
  - any_blk = |mon_block.
  - All transitions occur on the rising clock edge. Outputs are registered.
- IDLE:
  - enable=1 and ap_done=0 -> WATCH.
  - Counters and mask are held at 0.
- WATCH:
  - ap_done=1 or enable=0 -> IDLE (priority over any_blk).
  - any_blk=1 -> SUSPECT; block_run_cnt=1; deadlock_mask=mon_block; first_idx=lowest set index.
  - Otherwise stay in WATCH.
- SUSPECT:
  - ap_done=1 or enable=0 -> IDLE; clear block_run_cnt, deadlock_mask, first_idx (priority over everything).
  - any_blk=0 -> WATCH; clear block_run_cnt, deadlock_mask, first_idx.
  - any_blk=1 -> block_run_cnt+1; deadlock_mask |= mon_block.
  - If the incremented count equals THRESHOLD -> REPORTED and deadlock=1 in the same edge update.
- REPORTED:
  - Terminal until reset_n.
  - All outputs frozen; ap_done, enable and mon_block are ignored.
- suspect = (state==SUSPECT), registered with the state.
- Latency: deadlock is visible in the cycle after the edge that samples the THRESHOLD-th consecutive any_blk=1.
- A single any_blk=0 cycle fully restarts the run. There is no hysteresis.
- block_run_cnt never exceeds THRESHOLD, so it cannot wrap.
- A change in which monitors block does not restart the run. Any nonzero vector continues it.
- Asserting reset_n low while in SUSPECT or REPORTED immediately clears all outputs.

Optional Feature:
- Macro: AESL_DEADLOCK_AGG_TRACE_EN.
- Defined:
  - Adds output cycle_stamp (CNT_W), fed by a free-running cycle counter that resets to 0 and wraps modulo 2^CNT_W.
  - Adds output first_block_cycle (CNT_W): the counter value captured on the WATCH->SUSPECT edge.
  - first_block_cycle is cleared along with the mask and frozen in REPORTED.
  - The free-running counter keeps running in every state.
  - Simulation-only $display on entry to REPORTED, printing first_idx, deadlock_mask and first_block_cycle.
- Undefined:
  - Ports, counter and $display are absent.
  - All other behaviour is identical.

Test Plan (THRESHOLD=8, NUM_MON=4):
- Reset with enable=1 and mon_block=4'b0000 for 20 cycles -> state WATCH; suspect=0, deadlock=0, block_run_cnt=0.
- mon_block=4'b0100 held for 8 cycles -> suspect=1 from the 1st edge; first_idx=2; deadlock=1 after the 8th sampled edge; deadlock_mask=4'b0100; block_run_cnt=8.
- mon_block=4'b1000 for 5 cycles, then 0 for 1 cycle, then 4'b1000 for 7 cycles -> no deadlock; block_run_cnt restarts at 1 and reaches 7.
- mon_block alternates 4'b0010 and 4'b1000 for 8 cycles -> deadlock=1; deadlock_mask=4'b1010; first_idx=1.
- ap_done pulses on the same edge as the 6th blocked cycle -> state IDLE; block_run_cnt=0; deadlock=0.
- After deadlock, mon_block=0 and ap_done=1 applied -> outputs unchanged; then reset_n low mid-cycle -> all outputs 0 without waiting for a clock edge.
